// File: rtl/adder_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_accum : valid/ready burst accumulator around the 8-bit adder.      |
// | Option macro: ADDER_ACCUM_SAT_EN (saturating accumulate).  Rev 1.0       |
// +--------------------------------------------------------------------------+

module adder (
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic [7:0] sum
);
    assign sum = a_in + b_in;
endmodule

module adder_accum #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_ovf,
    output logic [7:0] out_count
);

    localparam logic [7:0] c_burst_len = 8'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       in_ready_q, in_ready_d;
    logic [7:0] out_sum_q, out_sum_d;
    logic       out_ovf_q, out_ovf_d;
    logic [7:0] out_count_q, out_count_d;

    logic [7:0] w_nsum;
    logic       w_carry;
    logic       w_accept;
    logic [7:0] w_count_inc;
    logic       w_end;
    logic [7:0] w_acc_upd;

    adder u_adder (
        .a_in (acc_q),
        .b_in (in_data),
        .sum  (w_nsum)
    );

    // Carry out of bit 7 recovered from the operand MSBs and the wrapped sum.
    assign w_carry     = (acc_q[7] & in_data[7]) | ((acc_q[7] ^ in_data[7]) & ~w_nsum[7]);
    assign w_accept    = in_valid & in_ready_q;
    assign w_count_inc = count_q + 8'd1;
    assign w_end       = in_last | (w_count_inc == c_burst_len);

`ifdef ADDER_ACCUM_SAT_EN
    // Once a burst has overflowed the accumulator stays pinned at full scale.
    assign w_acc_upd = (w_carry | ovf_q) ? 8'hFF : w_nsum;
`else
    assign w_acc_upd = w_nsum;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    acc_d   = w_acc_upd;
                    count_d = w_count_inc;
                    ovf_d   = ovf_q | w_carry;
                    if (w_end) begin
                        state_d     = S_HOLD;
                        out_sum_d   = w_acc_upd;
                        out_ovf_d   = ovf_q | w_carry;
                        out_count_d = w_count_inc;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    acc_d   = 8'h00;
                    count_d = 8'h00;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = 8'h00;
                count_d = 8'h00;
                ovf_d   = 1'b0;
            end
        endcase
        in_ready_d = (state_d != S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= 8'h00;
            count_q     <= 8'h00;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_sum_q   <= 8'h00;
            out_ovf_q   <= 1'b0;
            out_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_HOLD);
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adder_accum : randomized bench for adder_accum with reference model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_adder_accum;

    localparam int BURST_LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic [7:0] out_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_ops[$];

    adder_accum #(.BURST_LEN(BURST_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: running integer total, overflow whenever it passes 255.
    task automatic model(output logic [7:0] s, output logic o, output logic [7:0] c);
        int acc = 0;
        bit ov  = 0;
        for (int i = 0; i < q_ops.size(); i++) begin
            int t = acc + int'(q_ops[i]);
            if (t > 255) ov = 1;
`ifdef ADDER_ACCUM_SAT_EN
            acc = ov ? 255 : t;
`else
            acc = t % 256;
`endif
        end
        s = 8'(acc);
        o = ov;
        c = 8'(q_ops.size());
    endtask

    // Present one operand and wait until it is accepted; returns 1 time unit after the accept edge.
    task automatic beat(input logic [7:0] d, input logic last);
        int guard = 0;
        bit done  = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                guard++;
                if (guard > 50) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'b0;
    endtask

    task automatic send_burst(input bit use_last, input int max_gap, input int hold);
        logic [7:0] es, ec;
        logic       eo;
        model(es, eo, ec);
        out_ready = (hold == 0);
        for (int i = 0; i < q_ops.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #1;
            beat(q_ops[i], use_last && (i == q_ops.size() - 1));
            if (i != q_ops.size() - 1) check("mid_out_valid", 32'(out_valid), 32'd0);
        end
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_sum",   32'(out_sum),   32'(es));
        check("out_count", 32'(out_count), 32'(ec));
        check("out_ovf",   32'(out_ovf),   32'(eo));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                check("hold_valid",    32'(out_valid), 32'd1);
                check("hold_sum",      32'(out_sum),   32'(es));
                check("hold_count",    32'(out_count), 32'(ec));
                check("hold_in_ready", 32'(in_ready),  32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("release_valid",    32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready),  32'd1);
        check("release_sum_kept", 32'(out_sum),   32'(es));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        q_ops = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_burst(1'b0, 0, 0);
        check("t1_sum_const", 32'(out_sum), 32'h0A);

        q_ops = '{8'hF0, 8'h20, 8'h01, 8'h01};
        send_burst(1'b0, 0, 0);
`ifdef ADDER_ACCUM_SAT_EN
        check("t2_sum_const", 32'(out_sum), 32'hFF);
`else
        check("t2_sum_const", 32'(out_sum), 32'h12);
`endif

        q_ops = '{8'h55};
        send_burst(1'b1, 0, 0);
        check("t3_count_const", 32'(out_count), 32'd1);

        q_ops = '{8'h80, 8'h7F};
        send_burst(1'b1, 0, 5);
        q_ops = '{8'h03, 8'h04, 8'h05, 8'h06};
        send_burst(1'b0, 0, 0);

        // Reset in the middle of a burst must discard the partial total.
        beat(8'h10, 1'b0);
        beat(8'h10, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum",   32'(out_sum),   32'd0);
        rst_n = 1'b1;
        q_ops = '{8'h01, 8'h01, 8'h01, 8'h01};
        send_burst(1'b0, 0, 0);
        check("midrst_sum_const", 32'(out_sum), 32'h04);

        for (int b = 0; b < 100; b++) begin
            int  n;
            bit  ul;
            int  h;
            n  = $urandom_range(1, BURST_LEN);
            ul = (n < BURST_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            q_ops.delete();
            for (int i = 0; i < n; i++) q_ops.push_back(8'($urandom));
            send_burst(ul, 2, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_accum.md
# adder_accum

Sequential front end for the combinational 8-bit `adder` datapath. It accepts a stream of 8-bit operands over a valid/ready handshake and accumulates each burst through one `adder` instance (a_in = accumulator, b_in = operand). It publishes the burst total, a sticky overflow flag and the beat count through a one-entry output register with its own valid/ready handshake. It is the stage that drives `adder` operands and consumes its `sum`.

## Interface
- `BURST_LEN`, default 4: operands per burst unless `in_last` ends the burst early. Legal range 1..255.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  operand present.
- `in_ready`  output  1  block can accept an operand.
- `in_data`  input  8  operand.
- `in_last`  input  1  qualifies the operand as the final beat of the burst; sampled only on handshake.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  consumer accepts the result.
- `out_sum`  output  8  burst total.
- `out_ovf`  output  1  at least one beat in the burst carried out of bit 7.
- `out_count`  output  8  number of beats accepted in the burst.

## Operation
- Accept event: `in_valid & in_ready` at a rising edge. Release event: `out_valid & out_ready` at a rising edge.
- State machine:
  - IDLE: accumulator = 0, count = 0, ovf = 0.
  - ACCUM: the burst is in progress.
  - HOLD: a result is in the output register.
- `in_ready` = 1 in IDLE and ACCUM, and 0 in HOLD.
- Each accepted beat updates the burst state:
  - nsum = `adder` sum of (acc, in_data).
  - carry = (acc[7] & in_data[7]) | ((acc[7] ^ in_data[7]) & ~nsum[7]).
  - acc <= nsum, count <= count+1, ovf <= ovf | carry.
- Burst end is the accepted beat where `in_last` = 1 or count+1 == BURST_LEN. On that edge:
  - `out_sum`, `out_count` and `out_ovf` load from the post-update values.
  - State goes to HOLD.
- A beat in IDLE that does not end the burst moves the state to ACCUM. A beat that ends the burst goes straight to HOLD, so a one-beat burst works.
- HOLD on release: go to IDLE and clear acc, count and ovf. With no release, stay in HOLD and keep the outputs stable.
- With no accept, ACCUM holds its state indefinitely. Gaps in `in_valid` are legal.
- Arithmetic is modulo 256 (wrap) by default. `out_count` never exceeds BURST_LEN.

## Timing
- All outputs reset to 0 when `rst_n` is sampled low:
  - `in_ready` = 0 during the reset cycle, 1 on the first cycle after reset is released.
  - `out_valid` = 0, `out_sum` = 0x00, `out_ovf` = 0, `out_count` = 0x00.
  - State = IDLE.
- Reset mid-burst or in HOLD discards the partial sum or pending result. Nothing is emitted.
- Latency: `out_valid` rises on the cycle after the accept edge of the last beat.
- Throughput: 1 operand/cycle within a burst, plus 1 dead cycle for the release edge before the next burst is accepted.
- `in_ready` depends only on registered state, never combinationally on `out_ready`.
- `out_sum`, `out_ovf` and `out_count` are registered and change only on a burst end or reset.
- `in_valid` asserted while `in_ready` = 0 has no effect. The source must hold its data.

## Configuration
- `ADDER_ACCUM_SAT_EN` defined: saturating accumulate.
  - A beat with carry = 1 sets acc to 0xFF and sets ovf.
  - Later beats in the same burst keep acc at 0xFF. count still increments.
- `ADDER_ACCUM_SAT_EN` undefined: modulo-256 wrap as in Operation. `out_ovf` still reports the carry.

## Test plan
- Reset release, then BURST_LEN=4 with operands 0x01,0x02,0x03,0x04 and out_ready=1 -> out_valid one cycle after beat 4; out_sum=0x0A, out_count=4, out_ovf=0.
- Operands 0xF0,0x20,0x01,0x01 -> wrap build: out_sum=0x12, out_ovf=1. SAT build: out_sum=0xFF, out_ovf=1, out_count=4.
- Single beat 0x55 with in_last=1 -> out_valid next cycle; out_sum=0x55, out_count=1.
- out_ready=0 for 5 cycles after a result -> in_ready=0 and outputs stable throughout; out_ready=1 -> release, in_ready=1 next cycle, new burst starts from acc=0.
- Random in_valid gaps across 100 bursts of random operands -> every out_sum equals the reference sum mod 256 (or saturated in the SAT build).
- rst_n low for one cycle after 2 beats (0x10,0x10), then operands 0x01,0x01,0x01,0x01 -> out_sum=0x04, out_count=4.
